seq_signed_divider: RTL and testbench

Sequential signed restoring divider, the inverse operation of the team's sequential shift-add multiplier. Takes a two's-complement dividend and divisor, divides the magnitudes one quotient bit per clock, then applies signs. Quotient and remainder feed the same binary-to-BCD / seven-segment display path as the product. Uses a start/busy/done handshake driven by the control unit.

---
 rtl/seq_signed_divider.sv | 202 ++++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: one quotient bit per clock on
// magnitudes, then sign fix-up, with a start/busy/done handshake.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, honoured only in IDLE or DONE
//   dividend     : DIVIDEND_W-bit signed dividend
//   divisor      : DIVISOR_W-bit signed divisor
//   quotient     : signed quotient, truncated toward zero
//   remainder    : signed remainder, sign follows the dividend
//   busy         : operation in progress
//   done         : result valid, held until next accepted start
//   div_zero     : divisor was zero (qualified by done)
//   overflow     : quotient saturated (qualified by done)
//
// Optional feature macro: DIV_SHORTCUT_EN
//   When defined, |dividend| < |divisor| skips the DIVIDE phase.

module seq_signed_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic                  overflow
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] Q_MAX =
        {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN =
        {1'b1, {(DIVIDEND_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIVIDE,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIVIDEND_W-1:0] dvd_lat;
    logic [DIVIDEND_W-1:0] dvd_mag;
    logic [DIVIDEND_W-1:0] work;
    logic [DIVISOR_W-1:0]  dvs_lat;
    logic [DIVISOR_W-1:0]  dvs_mag_c;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [DIVISOR_W:0]    rem_mag;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W+1:0]  shifted;
    logic [CNT_W-1:0]      cnt;
    logic                  sign_q;
    logic                  sign_r;
    logic                  fits;
    logic                  short_hit;
    logic                  dvs_zero;
    logic                  accept;

    // Magnitudes are unsigned, so the most negative value maps to
    // 2^(W-1) without loss.
    always_comb begin
        dvd_mag = dvd_lat;
        if (dvd_lat[DIVIDEND_W-1])
            dvd_mag = ~dvd_lat + DIVIDEND_W'(1);
        dvs_mag_c = dvs_lat;
        if (dvs_lat[DIVISOR_W-1])
            dvs_mag_c = ~dvs_lat + DIVISOR_W'(1);
        dvs_zero = (dvs_lat == '0);
        // work holds the remaining dividend bits (MSB first) and
        // collects quotient bits at the LSB end.
        shifted = {rem_mag, work[DIVIDEND_W-1]};
        fits = (shifted >= (DIVISOR_W+2)'(dvs_mag));
        trial = shifted[DIVISOR_W:0] - (DIVISOR_W+1)'(dvs_mag);
`ifdef DIV_SHORTCUT_EN
        short_hit = (dvd_mag < DIVIDEND_W'(dvs_mag_c));
`else
        short_hit = 1'b0;
`endif
        accept = start &&
                 ((state == S_IDLE) || (state == S_DONE));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                if (dvs_zero)
                    state_next = S_DONE;
                else if (short_hit)
                    state_next = S_FIX;
                else
                    state_next = S_DIVIDE;
            end
            S_DIVIDE: begin
                busy = 1'b1;
                if (cnt == CNT_LAST)
                    state_next = S_FIX;
            end
            S_FIX: begin
                busy = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start)
                    state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_lat   <= '0;
            dvs_lat   <= '0;
            dvs_mag   <= '0;
            work      <= '0;
            rem_mag   <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                dvd_lat  <= dividend;
                dvs_lat  <= divisor;
                div_zero <= 1'b0;
                overflow <= 1'b0;
            end
            unique case (state)
                S_LOAD: begin
                    dvs_mag <= dvs_mag_c;
                    sign_q  <= dvd_lat[DIVIDEND_W-1] ^
                               dvs_lat[DIVISOR_W-1];
                    sign_r  <= dvd_lat[DIVIDEND_W-1];
                    cnt     <= '0;
                    rem_mag <= '0;
                    work    <= dvd_mag;
                    if (dvs_zero) begin
                        quotient  <= dvd_lat[DIVIDEND_W-1] ?
                                     Q_MIN : Q_MAX;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                    end else if (short_hit) begin
                        // Magnitude is below |divisor|, so it fits.
                        work    <= '0;
                        rem_mag <= (DIVISOR_W+1)'(dvd_mag);
                    end
                end
                S_DIVIDE: begin
                    rem_mag <= fits ? trial : shifted[DIVISOR_W:0];
                    work    <= {work[DIVIDEND_W-2:0], fits};
                    cnt     <= (cnt == CNT_LAST) ?
                               '0 : cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!sign_q && (work == Q_MIN)) begin
                        quotient  <= Q_MAX;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end else begin
                        quotient  <= sign_q ? -work : work;
                        remainder <= (sign_r && (rem_mag != '0)) ?
                                     -rem_mag[DIVISOR_W-1:0] :
                                     rem_mag[DIVISOR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: scoreboard of expected
// results, one task per scenario, handshake and latency checks.

module tb_seq_signed_divider;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] dividend;
    logic signed [7:0]  divisor;
    logic signed [15:0] quotient;
    logic signed [7:0]  remainder;
    logic               busy;
    logic               done;
    logic               div_zero;
    logic               overflow;

    typedef struct {
        int q;
        int r;
        bit dz;
        bit ov;
        int lat;
    } res_t;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    seq_signed_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Edges from the accepting edge (counted as 1) to done.
    function automatic int lat_of(input int a, input int b);
        if (b == 0)
            return 2;
`ifdef DIV_SHORTCUT_EN
        if (iabs(a) < iabs(b))
            return 3;
`endif
        return 19;
    endfunction

    function automatic res_t model(input int a, input int b);
        res_t e;
        e.dz = 0;
        e.ov = 0;
        e.lat = lat_of(a, b);
        if (b == 0) begin
            e.q = (a >= 0) ? 32767 : -32768;
            e.r = 0;
            e.dz = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            if (e.q == 32768) begin
                e.q = 32767;
                e.r = 0;
                e.ov = 1;
            end
        end
        return e;
    endfunction

    // Drive one request; returns #1 after the accepting edge with
    // the operand inputs scrambled.
    task automatic issue(input int a, input int b);
        @(negedge clk);
        dividend = 16'(a);
        divisor  = 8'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_done(input int first, output res_t got,
                             output bit hs, output res_t e);
        got.lat = first;
        hs = 1'b1;
        while (!done && got.lat < 60) begin
            if (busy !== 1'b1 || done !== 1'b0)
                hs = 1'b0;
            @(posedge clk);
            #1;
            got.lat++;
        end
        if (busy !== 1'b0)
            hs = 1'b0;
        got.q  = int'(quotient);
        got.r  = int'(remainder);
        got.dz = div_zero;
        got.ov = overflow;
        if (sb.size() == 0) begin
            e = '{0, 0, 0, 0, -1};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (quotient !== 16'sd0) begin
            n_err++;
            $display("FAIL reset quotient got %0d want 0", quotient);
        end
        n_vec++;
        if (remainder !== 8'sd0) begin
            n_err++;
            $display("FAIL reset remainder got %0d want 0", remainder);
        end
        n_vec++;
        if ({busy, done, div_zero, overflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset flags got %b want 0000",
                     {busy, done, div_zero, overflow});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_table(input string name, input int a[],
                              input int b[], input int q[],
                              input int r[], input bit ov[]);
        res_t got;
        res_t e;
        bit   hs;
        for (int i = 0; i < a.size(); i++) begin
            e = '{q[i], r[i], b[i] == 0, ov[i], lat_of(a[i], b[i])};
            sb.push_back(e);
            issue(a[i], b[i]);
            wait_done(1, got, hs, e);
            n_vec++;
            if (got.q !== e.q || got.r !== e.r) begin
                n_err++;
                $display("FAIL %s %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                         name, a[i], b[i], got.q, got.r, e.q, e.r);
            end
            n_vec++;
            if (got.dz !== e.dz || got.ov !== e.ov) begin
                n_err++;
                $display("FAIL %s %0d/%0d flags got dz=%0b ov=%0b want dz=%0b ov=%0b",
                         name, a[i], b[i], got.dz, got.ov, e.dz, e.ov);
            end
            n_vec++;
            if (got.lat !== e.lat || !hs) begin
                n_err++;
                $display("FAIL %s %0d/%0d latency got %0d hs=%0b want %0d hs=1",
                         name, a[i], b[i], got.lat, hs, e.lat);
            end
        end
    endtask

    task automatic test_basic();
        test_table("basic", '{100}, '{7}, '{14}, '{2}, '{0});
    endtask

    task automatic test_signs();
        test_table("signs",
                   '{-100, 100, -100, 1000, -1000},
                   '{7, -7, -7, -128, 3},
                   '{-14, -14, 14, -7, -333},
                   '{-2, 2, -2, 104, -1},
                   '{0, 0, 0, 0, 0});
    endtask

    task automatic test_overflow();
        test_table("overflow",
                   '{-32768, -32768, 32767},
                   '{-1, 1, -1},
                   '{32767, -32768, -32767},
                   '{0, 0, 0},
                   '{1, 0, 0});
    endtask

    task automatic test_div_zero();
        test_table("div_zero",
                   '{1234, -5, 0},
                   '{0, 0, 0},
                   '{32767, -32768, 32767},
                   '{0, 0, 0},
                   '{0, 0, 0});
    endtask

    task automatic test_shortcut();
        test_table("shortcut",
                   '{5, -5, 0, 127},
                   '{9, 9, -3, -128},
                   '{0, 0, 0, 0},
                   '{5, -5, 0, 127},
                   '{0, 0, 0, 0});
    endtask

    task automatic test_random();
        res_t got;
        res_t e;
        bit   hs;
        int   a;
        int   b;
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 255)) - 128;
            if (i % 5 == 0)
                a = a % 60;
            if (i % 11 == 3)
                b = 0;
            sb.push_back(model(a, b));
            issue(a, b);
            wait_done(1, got, hs, e);
            n_vec++;
            if (got.q !== e.q || got.r !== e.r ||
                got.dz !== e.dz || got.ov !== e.ov) begin
                n_err++;
                $display("FAIL random %0d/%0d got q=%0d r=%0d dz=%0b ov=%0b want q=%0d r=%0d dz=%0b ov=%0b",
                         a, b, got.q, got.r, got.dz, got.ov,
                         e.q, e.r, e.dz, e.ov);
            end
            n_vec++;
            if (got.lat !== e.lat || !hs) begin
                n_err++;
                $display("FAIL random %0d/%0d latency got %0d hs=%0b want %0d hs=1",
                         a, b, got.lat, hs, e.lat);
            end
        end
    endtask

    task automatic test_ignore_start();
        res_t got;
        res_t e;
        bit   hs;
        sb.push_back('{166, 2, 0, 0, 19});
        issue(500, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        dividend = -16'sd999;
        divisor  = 8'sd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, got, hs, e);
        n_vec++;
        if (got.q !== e.q || got.r !== e.r) begin
            n_err++;
            $display("FAIL ignore_start got q=%0d r=%0d want q=%0d r=%0d",
                     got.q, got.r, e.q, e.r);
        end
        n_vec++;
        if (got.lat !== e.lat || !hs) begin
            n_err++;
            $display("FAIL ignore_start latency got %0d hs=%0b want %0d hs=1",
                     got.lat, hs, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        res_t got;
        res_t e;
        bit   hs;
        issue(500, 3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, div_zero, overflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid flags got %b want 0000",
                     {busy, done, div_zero, overflow});
        end
        n_vec++;
        if (quotient !== 16'sd0 || remainder !== 8'sd0) begin
            n_err++;
            $display("FAIL reset_mid outputs got q=%0d r=%0d want q=0 r=0",
                     quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid idle got busy=%0b done=%0b want 0 0",
                     busy, done);
        end
        sb.push_back('{3, 2, 0, 0, lat_of(20, 6)});
        issue(20, 6);
        wait_done(1, got, hs, e);
        n_vec++;
        if (got.q !== e.q || got.r !== e.r || got.lat !== e.lat) begin
            n_err++;
            $display("FAIL reset_mid recover got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                     got.q, got.r, got.lat, e.q, e.r, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        res_t got;
        res_t e;
        bit   hs;
        sb.push_back('{14, 2, 0, 0, 19});
        issue(100, 7);
        wait_done(1, got, hs, e);
        n_vec++;
        if (got.q !== e.q || got.r !== e.r || got.lat !== e.lat) begin
            n_err++;
            $display("FAIL b2b first got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d",
                     got.q, got.r, got.lat, e.q, e.r, e.lat);
        end
        sb.push_back('{-333, -1, 0, 0, 19});
        issue(-1000, 3);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b1 || quotient !== 16'sd14) begin
            n_err++;
            $display("FAIL b2b accept got done=%0b busy=%0b q=%0d want 0 1 14",
                     done, busy, quotient);
        end
        wait_done(1, got, hs, e);
        n_vec++;
        if (got.q !== e.q || got.r !== e.r) begin
            n_err++;
            $display("FAIL b2b second got q=%0d r=%0d want q=%0d r=%0d",
                     got.q, got.r, e.q, e.r);
        end
        n_vec++;
        if (got.lat !== e.lat || !hs) begin
            n_err++;
            $display("FAIL b2b latency got %0d hs=%0b want %0d hs=1",
                     got.lat, hs, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_shortcut();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
